// File: rtl/adder_accumulator_ctrl.sv
// adder_accumulator_ctrl: sequencing stage around an external combinational adder.
// Holds the accumulator and launches acc + operand (+cin) into the attached adder.
// It then waits a fixed number of clocks for the adder to settle before it
// captures sum and carry-out. Clear operations load the accumulator directly.
module adder_accumulator_ctrl #(
  parameter int unsigned             WIDTH    = 16,
  parameter int unsigned             SETTLE   = 3,
  parameter logic [WIDTH-1:0]        ACC_INIT = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_cin,
  input  logic             in_clear,
  output logic [WIDTH-1:0] adder_a,
  output logic [WIDTH-1:0] adder_b,
  output logic             adder_cin,
  input  logic [WIDTH-1:0] adder_sum,
  input  logic             adder_cout,
  output logic [WIDTH-1:0] acc_out,
  output logic             cout_out,
  output logic             ovf_sticky,
  output logic             out_valid
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  // The counter is loaded with SETTLE-1 so the capture lands SETTLE edges after launch.
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE - 1);

  logic [0:0]       state_q,     state_d;
  logic [7:0]       cnt_q,       cnt_d;
  logic [WIDTH-1:0] acc_q,       acc_d;
  logic [WIDTH-1:0] adder_a_q,   adder_a_d;
  logic [WIDTH-1:0] adder_b_q,   adder_b_d;
  logic             adder_cin_q, adder_cin_d;
  logic             cout_q,      cout_d;
  logic             ovf_q,       ovf_d;
  logic             out_valid_q, out_valid_d;

  // Next-state logic: accept in IDLE, count down and capture in WAIT.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    adder_a_d   = adder_a_q;
    adder_b_d   = adder_b_q;
    adder_cin_d = adder_cin_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    out_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (in_clear) begin
            acc_d       = in_data;
            adder_a_d   = in_data;
            cout_d      = 1'b0;
            ovf_d       = 1'b0;
            out_valid_d = 1'b1;
          end else begin
            adder_a_d   = acc_q;
            adder_b_d   = in_data;
            adder_cin_d = in_cin;
            cnt_d       = SETTLE_LOAD;
            state_d     = ST_WAIT;
          end
        end else begin
          out_valid_d = 1'b0;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          acc_d       = adder_sum;
          adder_a_d   = adder_sum;
          cout_d      = adder_cout;
          ovf_d       = ovf_q | adder_cout;
          out_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // State registers. An asynchronous reset aborts any pending WAIT without capturing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      acc_q       <= ACC_INIT;
      adder_a_q   <= ACC_INIT;
      adder_b_q   <= '0;
      adder_cin_q <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      adder_a_q   <= adder_a_d;
      adder_b_q   <= adder_b_d;
      adder_cin_q <= adder_cin_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign adder_a    = adder_a_q;
  assign adder_b    = adder_b_q;
  assign adder_cin  = adder_cin_q;
  assign acc_out    = acc_q;
  assign cout_out   = cout_q;
  assign ovf_sticky = ovf_q;
  assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_adder_accumulator_ctrl.sv
// Scoreboard bench for adder_accumulator_ctrl with a behavioural 16-bit adder attached.
module tb_adder_accumulator_ctrl;

  localparam int SETTLE = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_cin;
  logic        in_clear;
  logic [15:0] adder_a;
  logic [15:0] adder_b;
  logic        adder_cin;
  logic [15:0] adder_sum;
  logic        adder_cout;
  logic [15:0] acc_out;
  logic        cout_out;
  logic        ovf_sticky;
  logic        out_valid;

  adder_accumulator_ctrl #(
    .WIDTH(16), .SETTLE(SETTLE), .ACC_INIT(16'h0000)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_cin(in_cin), .in_clear(in_clear),
    .adder_a(adder_a), .adder_b(adder_b), .adder_cin(adder_cin),
    .adder_sum(adder_sum), .adder_cout(adder_cout),
    .acc_out(acc_out), .cout_out(cout_out), .ovf_sticky(ovf_sticky),
    .out_valid(out_valid)
  );

  // Stand-in for the attached adder: a plain 17-bit sum.
  assign {adder_cout, adder_sum} = {1'b0, adder_a} + {1'b0, adder_b} + {16'h0000, adder_cin};

  always #12.5 clk = ~clk;

  typedef struct {
    logic [15:0] acc;
    logic        cout;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   count_en = 1'b0;
  int   rdy_low = 0;
  int   pulses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Handshake counters for the held-valid test.
  always @(negedge clk) begin
    if (count_en) begin
      if (!in_ready) rdy_low++;
      if (out_valid) pulses++;
    end
  end

  // Monitor: every out_valid pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (q.size() == 0) begin
        check("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("acc_out",    {16'h0000, acc_out}, {16'h0000, e.acc});
        check("cout_out",   {31'd0, cout_out},   {31'd0, e.cout});
        check("ovf_sticky", {31'd0, ovf_sticky}, {31'd0, e.ovf});
        check("latency",    cyc,                 e.cyc);
      end
    end
  end

  task automatic issue(input logic [15:0] d, input logic c, input logic clr,
                       input logic [15:0] ea, input logic ec, input logic eo, input bit push);
    int n;
    exp_t e;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 32'd0, 32'd1);
    in_data  = d;
    in_cin   = c;
    in_clear = clr;
    in_valid = 1'b1;
    if (push) begin
      e.acc  = ea;
      e.cout = ec;
      e.ovf  = eo;
      e.cyc  = cyc + 1 + (clr ? 0 : SETTLE);
      q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", q.size(), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 16'h0000;
    in_cin   = 1'b0;
    in_clear = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_acc",       {16'h0000, acc_out},  32'h0);
    check("rst_in_ready",  {31'd0, in_ready},    32'd1);
    check("rst_out_valid", {31'd0, out_valid},   32'd0);
    check("rst_adder_a",   {16'h0000, adder_a},  32'h0);
    check("rst_adder_b",   {16'h0000, adder_b},  32'h0);
    check("rst_adder_cin", {31'd0, adder_cin},   32'd0);
    check("rst_cout",      {31'd0, cout_out},    32'd0);
    check("rst_ovf",       {31'd0, ovf_sticky},  32'd0);

    // Reset while counter is 1: abort, no capture, no pulse
    issue(16'h0005, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    count_en = 1'b1;
    pulses = 0;
    check("abort_acc",      {16'h0000, acc_out}, 32'h0);
    check("abort_in_ready", {31'd0, in_ready},   32'd1);
    check("abort_adder_b",  {16'h0000, adder_b}, 32'h0);
    repeat (8) @(negedge clk);
    count_en = 1'b0;
    check("abort_no_pulse", pulses, 32'd0);

    // Clear then add with launch-register check
    issue(16'h1234, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b1);
    issue(16'h0001, 1'b0, 1'b0, 16'h1235, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b0;
    check("launch_adder_a",  {16'h0000, adder_a}, 32'h1234);
    check("launch_adder_b",  {16'h0000, adder_b}, 32'h0001);
    check("launch_in_ready", {31'd0, in_ready},   32'd0);
    drain();

    // Wrap with carry-out, sticky overflow survives a carry-free add
    issue(16'hFFFF, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1);
    issue(16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
    issue(16'h0005, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b1, 1'b1);
    drain();

    // Clear drops sticky; back-to-back clears; carry-in only
    issue(16'h00AA, 1'b0, 1'b1, 16'h00AA, 1'b0, 1'b0, 1'b1);
    issue(16'h7FFF, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b0, 1'b1);
    issue(16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1);
    check("launch_adder_cin", {31'd0, adder_cin}, 32'd1);
    drain();

    // in_valid held high across three adds
    issue(16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rdy_low  = 0;
    pulses   = 0;
    count_en = 1'b1;
    issue(16'h0010, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b1);
    issue(16'h0010, 1'b0, 1'b0, 16'h0020, 1'b0, 1'b0, 1'b1);
    issue(16'h0010, 1'b0, 1'b0, 16'h0030, 1'b0, 1'b0, 1'b1);
    drain();
    repeat (2) @(negedge clk);
    count_en = 1'b0;
    check("held_ready_low", rdy_low, 32'd9);
    check("held_pulses",    pulses,  32'd3);
    check("held_acc",       {16'h0000, acc_out}, 32'h0030);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog against a stuck run.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
